// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports, memory command bus and stall lines
// slave is the arbiter's view; master is the pipeline and memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_W/8-1:0]   dm_be;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  flush;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stall_fetch;
  logic                  stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, flush, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_fetch, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, flush, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall_fetch, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data stages
// One outstanding transaction of fixed latency; data side wins unless fetch has starved.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [STV_W-1:0]  starve, starve_nxt;
  logic              kill, kill_nxt;
  logic              store_q, store_nxt;
  logic              if_rvalid_q, if_rvalid_nxt;
  logic              dm_rvalid_q, dm_rvalid_nxt;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_nxt;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_nxt;
  logic              grant_if, grant_dm;
  logic              if_req_eff, contested;

  assign if_req_eff = bus.if_req & ~bus.flush;
  assign contested  = bus.dm_req & if_req_eff;

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    starve_nxt    = starve;
    kill_nxt      = kill;
    store_nxt     = store_q;
    if_rvalid_nxt = 1'b0;
    dm_rvalid_nxt = 1'b0;
    if_rdata_nxt  = if_rdata_q;
    dm_rdata_nxt  = dm_rdata_q;
    grant_if      = 1'b0;
    grant_dm      = 1'b0;

    case (state)
      S_IDLE: begin
        kill_nxt = 1'b0;
        // rst_n gating keeps grants and mem_en low while reset is held
        if (rst_n) begin
          if (bus.dm_req && !(contested && starve == STV_W'(STARVE_MAX))) begin
            grant_dm = 1'b1;
          end else if (if_req_eff) begin
            grant_if = 1'b1;
          end
        end
        if (grant_dm || grant_if) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_W'(1);
          owner_nxt = grant_dm ? OWN_DM : OWN_IF;
          store_nxt = grant_dm & bus.dm_we;
        end
        if (grant_if) begin
          starve_nxt = '0;
        end else if (grant_dm && contested && starve != STV_W'(STARVE_MAX)) begin
          starve_nxt = starve + STV_W'(1);
        end
      end
      S_WAIT: begin
        if (owner == OWN_IF && bus.flush) begin
          kill_nxt = 1'b1;
        end
        if (cnt == CNT_W'(LATENCY)) begin
          state_nxt = S_IDLE;
          kill_nxt  = 1'b0;
          if (owner == OWN_DM) begin
            dm_rvalid_nxt = 1'b1;
            dm_rdata_nxt  = store_q ? '0 : bus.mem_rdata;
          end else if (!(kill || bus.flush)) begin
            // a flush in the final wait cycle still counts as killing the fetch
            if_rvalid_nxt = 1'b1;
            if_rdata_nxt  = bus.mem_rdata;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= OWN_IF;
      cnt         <= '0;
      starve      <= '0;
      kill        <= 1'b0;
      store_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      starve      <= starve_nxt;
      kill        <= kill_nxt;
      store_q     <= store_nxt;
      if_rvalid_q <= if_rvalid_nxt;
      dm_rvalid_q <= dm_rvalid_nxt;
      if_rdata_q  <= if_rdata_nxt;
      dm_rdata_q  <= dm_rdata_nxt;
    end
  end

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

  assign bus.mem_en    = grant_if | grant_dm;
  assign bus.mem_we    = grant_dm & bus.dm_we;
  assign bus.mem_be    = grant_dm ? bus.dm_be : (grant_if ? '1 : '0);
  assign bus.mem_addr  = grant_dm ? bus.dm_addr : (grant_if ? bus.if_addr : '0);
  assign bus.mem_wdata = grant_dm ? bus.dm_wdata : '0;

  assign bus.stall_fetch = rst_n & ((bus.if_req & ~grant_if) | (state == S_WAIT && owner == OWN_IF));
  assign bus.stall_mem   = rst_n & ((bus.dm_req & ~grant_dm) | (state == S_WAIT && owner == OWN_DM));
endmodule
